// File: rtl/network_rx_assemble_if.sv
// network_rx_assemble_if: GMII receive, free-bufid handshake, buffer write port and descriptor handshake.
// master is the receiver's view, slave is the surrounding system's view.
interface network_rx_assemble_if;
  logic [7:0]   iv_gmii_rxd;
  logic         i_gmii_rx_dv;
  logic         i_gmii_rx_er;
  logic [8:0]   iv_free_bufid;
  logic         i_free_bufid_wr;
  logic         o_free_bufid_ack;
  logic [133:0] ov_pkt_wdata;
  logic [15:0]  ov_pkt_waddr;
  logic         o_pkt_wr;
  logic [8:0]   ov_pkt_bufid;
  logic [10:0]  ov_pkt_len;
  logic         o_pkt_bufid_wr;
  logic         i_pkt_bufid_ack;
  logic [15:0]  ov_drop_cnt;
  logic [2:0]   ov_rxc_state;
  modport master (
    input  iv_gmii_rxd, i_gmii_rx_dv, i_gmii_rx_er, iv_free_bufid, i_free_bufid_wr, i_pkt_bufid_ack,
    output o_free_bufid_ack, ov_pkt_wdata, ov_pkt_waddr, o_pkt_wr, ov_pkt_bufid, ov_pkt_len,
           o_pkt_bufid_wr, ov_drop_cnt, ov_rxc_state
  );
  modport slave (
    output iv_gmii_rxd, i_gmii_rx_dv, i_gmii_rx_er, iv_free_bufid, i_free_bufid_wr, i_pkt_bufid_ack,
    input  o_free_bufid_ack, ov_pkt_wdata, ov_pkt_waddr, o_pkt_wr, ov_pkt_bufid, ov_pkt_len,
           o_pkt_bufid_wr, ov_drop_cnt, ov_rxc_state
  );
endinterface

// File: rtl/network_rx_assemble.sv
// network_rx_assemble: strips GMII preamble/SFD, packs frame bytes into 134-bit buffer words under a prefetched bufid.
// Optional RX_FCS_CHECK_EN adds a CRC-32 residue check that drops frames with a bad FCS.
module network_rx_assemble #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input logic i_clk,
  input logic i_rst_n,
  network_rx_assemble_if.master bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, WAIT_SFD = 3'd1, RECV = 3'd2, DISCARD = 3'd3, REPORT = 3'd4} state_t;
  state_t state;
  logic [8:0] bufid;
  logic buf_v, cnt_drop, busy, pend_v, fcs_ok;
  logic [10:0] len, len_nx;
  logic [6:0] line;
  logic [3:0] cnt, inv;
  logic [127:0] sh, sh_nx, pend;
  logic [15:0] drop_cnt;
  logic dv;
  logic [7:0] rxd;
  assign dv = bus.i_gmii_rx_dv;
  assign rxd = bus.iv_gmii_rxd;
  assign len_nx = len + 11'(len != 11'h7ff);
  assign sh_nx = {sh[119:0], rxd};
  assign inv = 4'(5'd16 - 5'(cnt));
  assign bus.ov_pkt_bufid = bufid;
  assign bus.ov_pkt_len = len;
  assign bus.ov_drop_cnt = drop_cnt;
  assign bus.ov_rxc_state = state;
`ifdef RX_FCS_CHECK_EN
  logic [31:0] crc;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hedb88320 : r >> 1;
    return r;
  endfunction
  // reflected register form of the 0xC704DD7B residue
  assign fcs_ok = crc == 32'hdebb20e3;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) crc <= '0;
    else if (state != RECV) crc <= '1;
    else if (dv) crc <= crc_byte(crc, rxd);
`else
  assign fcs_ok = 1'b1;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      bufid <= '0;
      buf_v <= 1'b0;
      cnt_drop <= 1'b0;
      busy <= 1'b0;
      pend_v <= 1'b0;
      len <= '0;
      line <= '0;
      cnt <= '0;
      sh <= '0;
      pend <= '0;
      drop_cnt <= '0;
      bus.o_free_bufid_ack <= 1'b0;
      bus.ov_pkt_wdata <= '0;
      bus.ov_pkt_waddr <= '0;
      bus.o_pkt_wr <= 1'b0;
      bus.o_pkt_bufid_wr <= 1'b0;
    end else begin
      bus.o_free_bufid_ack <= !buf_v && bus.i_free_bufid_wr;
      if (!buf_v && bus.i_free_bufid_wr) begin
        bufid <= bus.iv_free_bufid;
        buf_v <= 1'b1;
      end
      bus.o_pkt_wr <= 1'b0;
      case (state)
        IDLE: if (dv) begin
          state <= rxd == 8'h55 ? WAIT_SFD : DISCARD;
          cnt_drop <= 1'b1;
        end
        WAIT_SFD:
          if (!dv) state <= IDLE;
          else if (rxd == 8'hd5) begin
            state <= buf_v ? RECV : DISCARD;
            cnt_drop <= 1'b1;
            len <= '0;
            line <= '0;
            cnt <= '0;
            pend_v <= 1'b0;
          end else if (rxd != 8'h55) begin
            state <= DISCARD;
            cnt_drop <= 1'b0;
          end
        RECV:
          if (!dv) begin
            // the last word, full or partial, is always the tail
            bus.o_pkt_wr <= len != 11'd0;
            bus.ov_pkt_wdata <= cnt == 4'd0 ? {2'b10, 4'd0, pend} : {2'b10, inv, sh << {inv, 3'b000}};
            bus.ov_pkt_waddr <= {bufid, line};
            if (len >= 11'(MIN_LEN) && fcs_ok) state <= REPORT;
            else begin
              state <= IDLE;
              drop_cnt <= drop_cnt + 16'd1;
            end
          end else if (bus.i_gmii_rx_er || len_nx > 11'(MAX_LEN)) begin
            state <= DISCARD;
            cnt_drop <= 1'b1;
          end else begin
            len <= len_nx;
            sh <= sh_nx;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              pend <= sh_nx;
              pend_v <= 1'b1;
            end
            // a completed word is released only once the next word has started
            if (cnt == 4'd0 && pend_v) begin
              bus.o_pkt_wr <= 1'b1;
              bus.ov_pkt_wdata <= {line == 7'd0 ? 2'b01 : 2'b11, 4'd0, pend};
              bus.ov_pkt_waddr <= {bufid, line};
              line <= line + 7'd1;
              pend_v <= 1'b0;
            end
          end
        DISCARD: if (!dv) begin
          state <= IDLE;
          if (cnt_drop) drop_cnt <= drop_cnt + 16'd1;
        end
        REPORT: begin
          busy <= dv;
          if (busy && !dv) drop_cnt <= drop_cnt + 16'd1;
          bus.o_pkt_bufid_wr <= !(bus.o_pkt_bufid_wr && bus.i_pkt_bufid_ack);
          // a frame already under way at ack time is finished off in DISCARD
          if (bus.o_pkt_bufid_wr && bus.i_pkt_bufid_ack) begin
            buf_v <= 1'b0;
            busy <= 1'b0;
            cnt_drop <= 1'b1;
            state <= dv ? DISCARD : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_network_rx_assemble.sv
// tb_network_rx_assemble: random GMII frames checked against a byte-level model of word packing, drops and descriptors.
`timescale 1ns/1ps
module tb_network_rx_assemble;
  localparam int MIN_LEN = 64, MAX_LEN = 1522;
  logic clk = 1'b0, rst_n = 1'b0;
  always #4 clk = ~clk;
  network_rx_assemble_if bus();
  network_rx_assemble #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  int total = 0, bad = 0;
  logic [149:0] wq[$];
  logic [7:0] frame[$];
  logic [15:0] exp_drop = '0;
  logic have_buf = 1'b0, desc_pend = 1'b0;
  logic [8:0] cur_bufid = '0;
  logic [10:0] desc_len = '0;

  task automatic check(input string tag, input logic [149:0] got, input logic [149:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (bus.o_pkt_wr) wq.push_back({bus.ov_pkt_waddr, bus.ov_pkt_wdata});

  function automatic logic [31:0] crc_of(input int n);
    logic [31:0] c;
    c = '1;
    for (int k = 0; k < n; k++) begin
      c = c ^ {24'd0, frame[k]};
      for (int j = 0; j < 8; j++) c = c[0] ? (c >> 1) ^ 32'hedb88320 : c >> 1;
    end
    return ~c;
  endfunction

  task automatic offer(input logic [8:0] id, input bit expect_ack);
    int t = 0;
    @(negedge clk);
    bus.iv_free_bufid = id;
    bus.i_free_bufid_wr = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.o_free_bufid_ack && t < 6);
    check("bufid_ack", 150'(bus.o_free_bufid_ack), 150'(expect_ack));
    bus.i_free_bufid_wr = 1'b0;
    @(negedge clk);
    check("ack_pulse", 150'(bus.o_free_bufid_ack), 150'(0));
    if (expect_ack) begin
      have_buf = 1'b1;
      cur_bufid = id;
    end
  endtask

  task automatic send_frame(input int n, input int er_at, input bit flip);
    int pre, acc, nw;
    logic capture, aborted, good, tail;
    logic [31:0] f;
    logic [127:0] d;
    frame.delete();
    for (int k = 0; k < n; k++) frame.push_back(8'($urandom));
    if (n >= 8) begin
      f = crc_of(n - 4) ^ {31'd0, flip};
      for (int k = 0; k < 4; k++) frame[n - 4 + k] = f[8 * k +: 8];
    end
    pre = $urandom_range(1, 7);
    for (int k = 0; k < pre + 1 + n; k++) begin
      @(negedge clk);
      bus.i_gmii_rx_dv = 1'b1;
      bus.iv_gmii_rxd = k < pre ? 8'h55 : k == pre ? 8'hd5 : frame[k - pre - 1];
      bus.i_gmii_rx_er = er_at != 0 && k - pre == er_at;
    end
    @(negedge clk);
    bus.i_gmii_rx_dv = 1'b0;
    bus.i_gmii_rx_er = 1'b0;
    repeat (6) @(negedge clk);
    capture = have_buf && !desc_pend;
    aborted = (er_at != 0 && er_at <= n) || n > MAX_LEN;
    acc = n;
    if (er_at != 0 && er_at - 1 < acc) acc = er_at - 1;
    if (acc > MAX_LEN) acc = MAX_LEN;
    good = capture && !aborted && n >= MIN_LEN;
`ifdef RX_FCS_CHECK_EN
    if (flip) good = 1'b0;
`endif
    nw = !capture ? 0 : aborted ? (acc > 0 ? (acc - 1) / 16 : 0) : (acc + 15) / 16;
    check("wr_count", 150'(wq.size()), 150'(nw));
    for (int w = 0; w < nw; w++) begin
      int c = acc - 16 * w;
      if (c > 16) c = 16;
      tail = !aborted && w == nw - 1;
      d = '0;
      for (int b = 0; b < c; b++) d[127 - 8 * b -: 8] = frame[16 * w + b];
      if (w < wq.size())
        check($sformatf("word%0d", w), wq[w],
              {cur_bufid, 7'(w), tail ? 2'b10 : w == 0 ? 2'b01 : 2'b11, tail ? 4'(16 - c) : 4'd0, d});
    end
    wq.delete();
    if (!good) exp_drop++;
    else begin
      desc_pend = 1'b1;
      desc_len = 11'(n);
    end
    check("drop_cnt", 150'(bus.ov_drop_cnt), 150'(exp_drop));
    check("desc_wr", 150'(bus.o_pkt_bufid_wr), 150'(desc_pend));
    check("state", 150'(bus.ov_rxc_state), desc_pend ? 150'(4) : 150'(0));
  endtask

  task automatic take_desc();
    int t = 0;
    while (!bus.o_pkt_bufid_wr && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("desc_seen", 150'(bus.o_pkt_bufid_wr), 150'(1));
    check("desc_bufid", 150'(bus.ov_pkt_bufid), 150'(cur_bufid));
    check("desc_len", 150'(bus.ov_pkt_len), 150'(desc_len));
    bus.i_pkt_bufid_ack = 1'b1;
    @(negedge clk);
    bus.i_pkt_bufid_ack = 1'b0;
    @(negedge clk);
    check("desc_release", 150'(bus.o_pkt_bufid_wr), 150'(0));
    desc_pend = 1'b0;
    have_buf = 1'b0;
  endtask

  initial begin
    int n, er;
    bus.iv_gmii_rxd = '0;
    bus.i_gmii_rx_dv = 1'b0;
    bus.i_gmii_rx_er = 1'b0;
    bus.iv_free_bufid = '0;
    bus.i_free_bufid_wr = 1'b0;
    bus.i_pkt_bufid_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr", 150'(bus.o_pkt_wr), 150'(0));
    check("rst_desc", 150'(bus.o_pkt_bufid_wr), 150'(0));
    check("rst_ack", 150'(bus.o_free_bufid_ack), 150'(0));
    check("rst_drop", 150'(bus.ov_drop_cnt), 150'(0));
    check("rst_state", 150'(bus.ov_rxc_state), 150'(0));
    check("rst_waddr", 150'(bus.ov_pkt_waddr), 150'(0));
    rst_n = 1'b1;
    offer(9'h005, 1'b1);
    offer(9'h123, 1'b0);
    send_frame(64, 0, 1'b0);
    take_desc();
    offer(9'($urandom), 1'b1);
    send_frame(65, 0, 1'b0);
    take_desc();
    offer(9'($urandom), 1'b1);
    send_frame(100, 30, 1'b0);
    send_frame(80, 0, 1'b0);
    take_desc();
    send_frame(70, 0, 1'b0);
    offer(9'($urandom), 1'b1);
    send_frame(64, 0, 1'b0);
    take_desc();
    offer(9'($urandom), 1'b1);
    send_frame(1600, 0, 1'b0);
    send_frame(40, 0, 1'b0);
    send_frame(64, 0, 1'b0);
    take_desc();
    offer(9'($urandom), 1'b1);
    send_frame(72, 0, 1'b0);
    send_frame(66, 0, 1'b0);
    take_desc();
`ifdef RX_FCS_CHECK_EN
    offer(9'($urandom), 1'b1);
    send_frame(64, 0, 1'b1);
    send_frame(64, 0, 1'b0);
    take_desc();
`endif
    for (int i = 0; i < 15; i++) begin
      if (!have_buf && $urandom_range(0, 3) != 0) offer(9'($urandom), 1'b1);
      n = $urandom_range(20, 300);
      er = $urandom_range(0, 4) == 0 ? $urandom_range(1, n) : 0;
      send_frame(n, er, 1'b0);
      if (desc_pend) take_desc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
